// File: rtl/systolic_pkg.sv
// Shared definitions for the 4x4 output-stationary systolic array family
// (input controller, array, output collector).
//
// Contents:
//   N, DW          array dimension and element width
//   IdxW, TCntW    widths of a row/column index and of the skew time counter
//   ctrl_state_e   input-controller state encoding
//   elem_sel()     pick element idx out of a packed N*DW vector
package systolic_pkg;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;

    localparam int unsigned IdxW  = (N > 1) ? $clog2(N) : 1;
    // Skew time t spans 0..2N-2.
    localparam int unsigned TCntW = $clog2(2 * N);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStream,
        StDrain,
        StDone
    } ctrl_state_e;

    // Element idx lives at bits [idx*DW +: DW]; a shift keeps the select width-clean.
    function automatic logic [DW-1:0] elem_sel(input logic [N*DW-1:0] vec,
                                               input int unsigned     idx);
        logic [N*DW-1:0] shifted;
        shifted = vec >> (idx * DW);
        return shifted[DW-1:0];
    endfunction

endpackage

// File: rtl/skew_buffer.sv
// N x N storage for one A and one B matrix with a diagonally skewed read port.
//
// Ports:
//   clk       clock (storage has no reset; contents are don't-care until loaded)
//   wr_en     write one beat
//   wr_idx    beat index k
//   wr_a_col  A[0..N-1][k], element i at [i*DW +: DW]
//   wr_b_row  B[k][0..N-1], element j at [j*DW +: DW]
//   rd_t      skew time t
//   rd_a      element i = A[i][t-i] when 0 <= t-i < N, else 0
//   rd_b      element j = B[t-j][j] when 0 <= t-j < N, else 0
module skew_buffer
    import systolic_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IdxW-1:0]   wr_idx,
    input  logic [N*DW-1:0]   wr_a_col,
    input  logic [N*DW-1:0]   wr_b_row,
    input  logic [TCntW-1:0]  rd_t,
    output logic [N*DW-1:0]   rd_a,
    output logic [N*DW-1:0]   rd_b
);

    // Lane g stores row g of A and column g of B, both indexed by k, so the
    // skewed read for lane g is simply entry (t - g) of its own storage.
    for (genvar g = 0; g < N; g++) begin : g_lane
        localparam logic [TCntW-1:0] Skew = TCntW'(g);

        logic [DW-1:0]    a_row [N];
        logic [DW-1:0]    b_col [N];
        logic [TCntW-1:0] rel;
        logic             hit;

        always_ff @(posedge clk) begin
            if (wr_en) begin
                a_row[wr_idx] <= elem_sel(wr_a_col, g);
                b_col[wr_idx] <= elem_sel(wr_b_row, g);
            end
        end

        assign rel = rd_t - Skew;
        // rel wraps when t < g; the first term masks that case.
        assign hit = (rd_t >= Skew) && (rel < TCntW'(N));

        assign rd_a[g*DW +: DW] = hit ? a_row[rel[IdxW-1:0]] : '0;
        assign rd_b[g*DW +: DW] = hit ? b_col[rel[IdxW-1:0]] : '0;
    end

endmodule

// File: rtl/systolic_input_ctrl.sv
// Upstream feeder for the N x N output-stationary systolic array.
// Buffers one A and one B matrix (N load beats), replays them with diagonal
// skew, drives the array's start / in_valid, then pulses done after a
// programmable drain period so downstream can sample C.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clear         synchronous abort to idle, buffer discarded
//   load_valid    load beat present; accepted when load_valid & load_ready
//   load_ready    high in idle and load
//   load_a_col    beat k: A[i][k] at [i*DW +: DW]
//   load_b_row    beat k: B[k][j] at [j*DW +: DW]
//   arr_start     array start (stream and drain)
//   arr_in_valid  array in_valid (stream only)
//   a_out, b_out  skewed operands, zero padded
//   busy          high in every state except idle
//   done          one-cycle pulse at the end of drain
// All outputs are registered.
module systolic_input_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [N*DW-1:0] load_a_col,
    input  logic [N*DW-1:0] load_b_row,
    output logic            arr_start,
    output logic            arr_in_valid,
    output logic [N*DW-1:0] a_out,
    output logic [N*DW-1:0] b_out,
    output logic            busy,
    output logic            done
);

    localparam int unsigned DrainW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    localparam logic [IdxW-1:0]   LastBeat  = IdxW'(N - 1);
    localparam logic [TCntW-1:0]  LastT     = TCntW'(2 * N - 2);
    localparam logic [DrainW-1:0] LastDrain =
        DrainW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    ctrl_state_e       state_q, state_d;
    logic [IdxW-1:0]   beat_q, beat_d;
    logic [TCntW-1:0]  t_q, t_d;
    logic [DrainW-1:0] drain_q, drain_d;

    logic              load_ready_q, load_ready_d;
    logic              arr_start_q, arr_start_d;
    logic              arr_in_valid_q, arr_in_valid_d;
    logic [N*DW-1:0]   a_out_q, a_out_d;
    logic [N*DW-1:0]   b_out_q, b_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept;
    logic              wr_en;
    logic [IdxW-1:0]   wr_idx;
    logic [N*DW-1:0]   skew_a, skew_b;

    // clear wins over a simultaneous beat; the beat is dropped.
    assign accept = load_valid && !clear;

    // The read port looks at the next t so the registered outputs line up with
    // the registered state. On STREAM entry t_d = 0, which only needs beat 0,
    // so the beat written on that same edge is never read too early.
    skew_buffer u_skew_buffer (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_a_col (load_a_col),
        .wr_b_row (load_b_row),
        .rd_t     (t_d),
        .rd_a     (skew_a),
        .rd_b     (skew_b)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        t_d     = t_q;
        drain_d = drain_q;
        wr_en   = 1'b0;
        wr_idx  = beat_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                    beat_d  = IdxW'(1);
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (beat_q == LastBeat) begin
                        beat_d  = '0;
                        t_d     = '0;
                        state_d = StStream;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StStream: begin
                if (t_q == LastT) begin
                    t_d     = '0;
                    drain_d = '0;
                    state_d = (DRAIN_CYCLES == 0) ? StDone : StDrain;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == LastDrain) begin
                    drain_d = '0;
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (clear) begin
            state_d = StIdle;
            beat_d  = '0;
            t_d     = '0;
            drain_d = '0;
            wr_en   = 1'b0;
        end

        // Output values for the state being entered; in idle they equal the
        // reset values, which is what clear relies on.
        load_ready_d   = (state_d == StIdle) || (state_d == StLoad);
        arr_start_d    = (state_d == StStream) || (state_d == StDrain);
        arr_in_valid_d = (state_d == StStream);
        busy_d         = (state_d != StIdle);
        done_d         = (state_d == StDone);
        a_out_d        = (state_d == StStream) ? skew_a : '0;
        b_out_d        = (state_d == StStream) ? skew_b : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            beat_q         <= '0;
            t_q            <= '0;
            drain_q        <= '0;
            load_ready_q   <= 1'b1;
            arr_start_q    <= 1'b0;
            arr_in_valid_q <= 1'b0;
            a_out_q        <= '0;
            b_out_q        <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            t_q            <= t_d;
            drain_q        <= drain_d;
            load_ready_q   <= load_ready_d;
            arr_start_q    <= arr_start_d;
            arr_in_valid_q <= arr_in_valid_d;
            a_out_q        <= a_out_d;
            b_out_q        <= b_out_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign load_ready   = load_ready_q;
    assign arr_start    = arr_start_q;
    assign arr_in_valid = arr_in_valid_q;
    assign a_out        = a_out_q;
    assign b_out        = b_out_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_systolic_input_ctrl.sv
// Bench for systolic_input_ctrl: a DRAIN_CYCLES=8 instance plus a DRAIN_CYCLES=0
// instance sharing the same stimulus. Expected streams come from the A/B
// matrices held here and the skew rule a[i] = A[i][t-i], b[j] = B[t-j][j].
module tb_systolic_input_ctrl;
    import systolic_pkg::*;

    localparam int Drain = 8;
    localparam int SL    = 2 * int'(N) - 1;  // stream length in cycles
    localparam int VW    = int'(N * DW);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          clear;
    logic          load_valid;
    logic          load_valid0;
    logic          garbage;
    logic [VW-1:0] load_a_col;
    logic [VW-1:0] load_b_row;

    logic          load_ready, arr_start, arr_in_valid, busy, done;
    logic [VW-1:0] a_out, b_out;
    logic          load_ready0, arr_start0, arr_in_valid0, busy0, done0;
    logic [VW-1:0] a_out0, b_out0;

    // Garbage beats offered mid-stream only go to the main instance; the
    // zero-drain instance is already idle then and would accept them.
    assign load_valid0 = load_valid & ~garbage;

    systolic_input_ctrl #(.DRAIN_CYCLES(Drain)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_a_col   (load_a_col),
        .load_b_row   (load_b_row),
        .arr_start    (arr_start),
        .arr_in_valid (arr_in_valid),
        .a_out        (a_out),
        .b_out        (b_out),
        .busy         (busy),
        .done         (done)
    );

    systolic_input_ctrl #(.DRAIN_CYCLES(0)) u_dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .load_valid   (load_valid0),
        .load_ready   (load_ready0),
        .load_a_col   (load_a_col),
        .load_b_row   (load_b_row),
        .arr_start    (arr_start0),
        .arr_in_valid (arr_in_valid0),
        .a_out        (a_out0),
        .b_out        (b_out0),
        .busy         (busy0),
        .done         (done0)
    );

    logic [DW-1:0] ma [N][N];  // ma[i][k] = A[i][k]
    logic [DW-1:0] mb [N][N];  // mb[k][j] = B[k][j]

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected operand vectors c cycles after the first stream beat.
    function automatic logic [VW-1:0] exp_a(input int c);
        logic [VW-1:0] v;
        int k;
        v = '0;
        for (int i = 0; i < int'(N); i++) begin
            k = c - i;
            if (c < SL && k >= 0 && k < int'(N)) v[i*DW +: DW] = ma[i][k];
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] exp_b(input int c);
        logic [VW-1:0] v;
        int k;
        v = '0;
        for (int j = 0; j < int'(N); j++) begin
            k = c - j;
            if (c < SL && k >= 0 && k < int'(N)) v[j*DW +: DW] = mb[k][j];
        end
        return v;
    endfunction

    task automatic fill_ident();
        for (int i = 0; i < int'(N); i++)
            for (int k = 0; k < int'(N); k++) begin
                ma[i][k] = DW'(10 * i + k + 1);
                mb[i][k] = DW'(16 * i + k + 1);
            end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < int'(N); i++)
            for (int k = 0; k < int'(N); k++) begin
                ma[i][k] = DW'($urandom);
                mb[i][k] = DW'($urandom);
            end
    endtask

    // Called at a negedge; returns at the negedge after the last accepted beat.
    task automatic load(input int gap, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            load_valid = 1'b1;
            for (int i = 0; i < int'(N); i++) begin
                load_a_col[i*DW +: DW] = ma[i][k];
                load_b_row[i*DW +: DW] = mb[k][i];
            end
            chk1($sformatf("load_ready beat %0d", k), load_ready, 1'b1);
            @(negedge clk);
            load_valid = 1'b0;
            chk1($sformatf("busy after beat %0d", k), busy, 1'b1);
            if (k != nbeats - 1) begin
                for (int g = 0; g < gap; g++) begin
                    load_a_col = VW'($urandom);
                    load_b_row = VW'($urandom);
                    chk1("load_ready in gap", load_ready, 1'b1);
                    chk1("arr_in_valid in gap", arr_in_valid, 1'b0);
                    @(negedge clk);
                end
            end
        end
    endtask

    // Checks cycles c = 0..last_c after the final load accept; c = 0 is the
    // first stream beat. The done pulse occupies cycle SL+Drain, i.e. it is the
    // (2N-1+DRAIN+1)-th cycle counting the first stream beat as cycle 1.
    task automatic run_stream(input bit garb, input bit ident, input int last_c);
        for (int c = 0; c <= last_c; c++) begin
            chkv($sformatf("a_out c=%0d", c), a_out, exp_a(c));
            chkv($sformatf("b_out c=%0d", c), b_out, exp_b(c));
            chk1($sformatf("arr_in_valid c=%0d", c), arr_in_valid, c < SL);
            chk1($sformatf("arr_start c=%0d", c), arr_start, c < SL + Drain);
            chk1($sformatf("done c=%0d", c), done, c == SL + Drain);
            chk1($sformatf("busy c=%0d", c), busy, c <= SL + Drain);
            chk1($sformatf("load_ready c=%0d", c), load_ready, c > SL + Drain);
            chkv($sformatf("d0 a_out c=%0d", c), a_out0, exp_a(c));
            chk1($sformatf("d0 arr_start c=%0d", c), arr_start0, c < SL);
            chk1($sformatf("d0 done c=%0d", c), done0, c == SL);
            chk1($sformatf("d0 busy c=%0d", c), busy0, c <= SL);
            if (ident) begin
                if (c == 0) begin
                    chkv("ident a t0", a_out, 32'h0000_0001);
                    chkv("ident b t0", b_out, 32'h0000_0001);
                end
                if (c == 3) begin
                    chkv("ident a t3", a_out, 32'h1f16_0d04);
                    chkv("ident b t3", b_out, 32'h0413_2231);
                end
                if (c == 6) begin
                    chkv("ident a t6", a_out, 32'h2200_0000);
                    chkv("ident b t6", b_out, 32'h3400_0000);
                end
            end
            if (garb && c < SL + Drain) begin
                garbage    = 1'b1;
                load_valid = 1'b1;
                load_a_col = VW'($urandom);
                load_b_row = VW'($urandom);
            end else begin
                garbage    = 1'b0;
                load_valid = 1'b0;
            end
            if (c != last_c) @(negedge clk);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk1({tag, " load_ready"}, load_ready, 1'b1);
        chk1({tag, " arr_start"}, arr_start, 1'b0);
        chk1({tag, " arr_in_valid"}, arr_in_valid, 1'b0);
        chkv({tag, " a_out"}, a_out, '0);
        chkv({tag, " b_out"}, b_out, '0);
        chk1({tag, " busy"}, busy, 1'b0);
        chk1({tag, " done"}, done, 1'b0);
        chk1({tag, " d0 busy"}, busy0, 1'b0);
        chk1({tag, " d0 arr_start"}, arr_start0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        clear      = 1'b0;
        load_valid = 1'b0;
        garbage    = 1'b0;
        load_a_col = '0;
        load_b_row = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("after reset");

        // Back-to-back load of known matrices.
        fill_ident();
        load(0, int'(N));
        run_stream(1'b0, 1'b1, SL + Drain + 1);

        // Same matrices with two idle cycles between beats.
        load(2, int'(N));
        run_stream(1'b0, 1'b1, SL + Drain + 1);

        // Beats offered during stream/drain must be ignored.
        fill_rand();
        load(0, int'(N));
        run_stream(1'b1, 1'b0, SL + Drain + 1);
        fill_rand();
        load(1, int'(N));
        run_stream(1'b0, 1'b0, SL + Drain + 1);

        // clear at t = 3.
        fill_rand();
        load(0, int'(N));
        run_stream(1'b0, 1'b0, 3);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk_idle("after clear");
        for (int c = 0; c < 20; c++) begin
            chk1($sformatf("no done after clear %0d", c), done | done0, 1'b0);
            @(negedge clk);
        end

        // clear with a beat in idle, then in load: the beat is dropped.
        load_valid = 1'b1;
        clear      = 1'b1;
        @(negedge clk);
        chk1("clear+beat in idle busy", busy, 1'b0);
        load_valid = 1'b0;
        clear      = 1'b0;
        load(0, 2);
        load_valid = 1'b1;
        clear      = 1'b1;
        @(negedge clk);
        chk1("clear+beat in load busy", busy, 1'b0);
        chk1("clear+beat in load ready", load_ready, 1'b1);
        load_valid = 1'b0;
        clear      = 1'b0;
        fill_rand();
        load(0, int'(N));
        run_stream(1'b0, 1'b0, SL + Drain + 1);

        // Asynchronous reset mid-drain.
        fill_rand();
        load(0, int'(N));
        run_stream(1'b0, 1'b0, SL + 3);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        fill_rand();
        load(0, int'(N));
        run_stream(1'b0, 1'b0, SL + Drain + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
